// File: rtl/ascii_num_parser.sv
// Byte-stream parser: turns ASCII decimal tokens from a UART into signed numbers, one line at a time.
// Optional build macro NEG_NUM_EN enables a leading '-' sign prefix on tokens.
module ascii_num_parser #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] num_data,
  output logic                  num_valid,
  output logic                  line_done,
  output logic [7:0]            line_len,
  output logic                  parse_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2
  } state_t;

  localparam int AW = DATA_WIDTH + 4;
  localparam logic [AW-1:0] MAX_MAG = {5'b00000, {(DATA_WIDTH-1){1'b1}}};

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic                  neg;
  logic                  has_digit;
  logic [7:0]            count;

  logic                  is_digit;
  logic                  is_sep;
  logic                  is_lf;
  logic                  is_minus;
  logic                  sign_en;
  logic [AW-1:0]         acc_next;
  logic                  overflow;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] signed_val(input logic [DATA_WIDTH-1:0] mag,
                                                       input logic               n);
    return n ? (~mag + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : mag;
  endfunction

`ifdef NEG_NUM_EN
  assign sign_en = 1'b1;
`else
  assign sign_en = 1'b0;
`endif

  // Byte classification and the next accumulator value with its overflow check
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_sep   = (rx_data == 8'h20) || (rx_data == 8'h09) ||
               (rx_data == 8'h2C) || (rx_data == 8'h0D);
    is_lf    = (rx_data == 8'h0A);
    is_minus = (rx_data == 8'h2D);
    // acc <= MAX_MAG always, so the four spare bits cannot wrap
    acc_next = (AW'(acc) << 3) + (AW'(acc) << 1) + AW'(rx_data[3:0]);
    overflow = acc_next > MAX_MAG;
  end

  // Parser FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      neg         <= 1'b0;
      has_digit   <= 1'b0;
      count       <= 8'd0;
      num_data    <= '0;
      num_valid   <= 1'b0;
      line_done   <= 1'b0;
      line_len    <= 8'd0;
      parse_error <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      line_done <= 1'b0;
      if (clear) begin
        state       <= IDLE;
        acc         <= '0;
        neg         <= 1'b0;
        has_digit   <= 1'b0;
        count       <= 8'd0;
        parse_error <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              acc       <= acc_next[DATA_WIDTH-1:0];
              neg       <= 1'b0;
              has_digit <= 1'b1;
              state     <= ACCUM;
            end else if (sign_en && is_minus) begin
              acc       <= '0;
              neg       <= 1'b1;
              has_digit <= 1'b0;
              state     <= ACCUM;
            end else if (is_lf) begin
              line_done <= 1'b1;
              line_len  <= count;
              count     <= 8'd0;
            end else if (!is_sep) begin
              parse_error <= 1'b1;
              state       <= SKIP;
            end
          end
          ACCUM: begin
            if (is_digit) begin
              if (overflow) begin
                parse_error <= 1'b1;
                acc         <= '0;
                neg         <= 1'b0;
                has_digit   <= 1'b0;
                state       <= SKIP;
              end else begin
                acc       <= acc_next[DATA_WIDTH-1:0];
                has_digit <= 1'b1;
              end
            end else if (is_sep || is_lf) begin
              acc       <= '0;
              neg       <= 1'b0;
              has_digit <= 1'b0;
              if (has_digit) begin
                num_data  <= signed_val(acc, neg);
                num_valid <= 1'b1;
              end else begin
                // lone sign with no digits
                parse_error <= 1'b1;
              end
              if (is_lf) begin
                line_done <= 1'b1;
                line_len  <= has_digit ? sat_inc(count) : count;
                count     <= 8'd0;
                state     <= IDLE;
              end else begin
                count <= has_digit ? sat_inc(count) : count;
                state <= has_digit ? IDLE : SKIP;
              end
            end else begin
              parse_error <= 1'b1;
              acc         <= '0;
              neg         <= 1'b0;
              has_digit   <= 1'b0;
              state       <= SKIP;
            end
          end
          SKIP: begin
            if (is_lf) begin
              line_done <= 1'b1;
              line_len  <= count;
              count     <= 8'd0;
              state     <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            acc       <= '0;
            neg       <= 1'b0;
            has_digit <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
